// File: rtl/core_seq_pkg.sv
// Shared definitions for the multi-cycle core sequencer: state encoding,
// RV32I major opcodes and next-PC select encodings.
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] PCSEL_PC4  = 2'b00;
    localparam logic [1:0] PCSEL_IMM  = 2'b01;
    localparam logic [1:0] PCSEL_JALR = 2'b10;

    // jalr has priority over a taken branch/jal
    function automatic logic [1:0] pc_sel_decode(input logic jalr_i, input logic pc_src_i);
        if (jalr_i)
            return PCSEL_JALR;
        else if (pc_src_i)
            return PCSEL_IMM;
        else
            return PCSEL_PC4;
    endfunction

endpackage

// File: rtl/core_sequencer_opclass.sv
// Combinational RV32I opcode classifier used by the core sequencer.
module seq_opclass
    import core_seq_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       needs_wb,
    output logic       illegal
);

    // Map the major opcode onto the classes the sequencer branches on
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        needs_wb  = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_LOAD:   begin is_load = 1'b1; needs_wb = 1'b1; end
            OPC_STORE:  is_store  = 1'b1;
            OPC_BRANCH: is_branch = 1'b1;
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                        needs_wb  = 1'b1;
            default:    illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the unpipelined RISC-V core.
// Steps IF -> ID -> EX -> (MEM) -> (WB), commits the PC once per instruction
// and faults on illegal opcodes or memory handshakes that exceed MEM_TIMEOUT.
// Optional: define CORE_SEQ_INSTRET_EN to build the 32-bit retired counter.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        if_en,
    input  logic [6:0]  opcode,
    output logic        id_en,
    output logic        ex_en,
    input  logic        PC_src,
    input  logic        jalr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        wb_en,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] instret
);

    localparam int unsigned CW_RAW = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned CW     = (CW_RAW == 0) ? 1 : CW_RAW;
    localparam logic [CW-1:0] TMO  = CW'(MEM_TIMEOUT);

    state_t        r_state;
    logic [1:0]    r_pc_sel;
    logic [CW-1:0] r_cnt;

    logic   w_is_load, w_is_store, w_is_branch, w_needs_wb, w_illegal;
    logic   w_ready;
    logic   w_timeout;
    logic   w_commit;
    logic [1:0] w_exec_sel;
    state_t w_after_commit;

    seq_opclass u_opclass (
        .opcode    (opcode),
        .is_load   (w_is_load),
        .is_store  (w_is_store),
        .is_branch (w_is_branch),
        .needs_wb  (w_needs_wb),
        .illegal   (w_illegal)
    );

    assign w_ready        = (r_state == ST_MEM) ? dmem_ready : imem_ready;
    assign w_timeout      = !w_ready && (r_cnt == TMO);
    assign w_exec_sel     = pc_sel_decode(jalr, PC_src);
    assign w_after_commit = run ? ST_FETCH : ST_IDLE;

    // State register, wait counter and latched next-PC select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pc_sel <= PCSEL_PC4;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state <= ST_FETCH;
                        r_cnt   <= '0;
                    end
                end
                ST_FETCH: begin
                    if (imem_ready)
                        r_state <= ST_DECODE;
                    else if (w_timeout)
                        r_state <= ST_FAULT;
                    else
                        r_cnt <= r_cnt + CW'(1);
                end
                ST_DECODE: r_state <= ST_EXEC;
                ST_EXEC: begin
                    r_pc_sel <= w_exec_sel;
                    if (w_illegal)
                        r_state <= ST_FAULT;
                    else if (w_is_load || w_is_store) begin
                        r_state <= ST_MEM;
                        r_cnt   <= '0;
                    end else if (w_is_branch) begin
                        r_state <= w_after_commit;
                        r_cnt   <= '0;
                    end else if (w_needs_wb)
                        r_state <= ST_WB;
                    else
                        r_state <= ST_FAULT;
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (w_is_store) begin
                            r_state <= w_after_commit;
                            r_cnt   <= '0;
                        end else
                            r_state <= ST_WB;
                    end else if (w_timeout)
                        r_state <= ST_FAULT;
                    else
                        r_cnt <= r_cnt + CW'(1);
                end
                ST_WB: begin
                    r_state <= w_after_commit;
                    r_cnt   <= '0;
                end
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_FAULT;
            endcase
        end
    end

    assign w_commit = ((r_state == ST_EXEC) && w_is_branch && !w_illegal)
                    || ((r_state == ST_MEM) && w_is_store && dmem_ready)
                    || (r_state == ST_WB);

    assign imem_req = (r_state == ST_FETCH);
    assign if_en    = (r_state == ST_FETCH) && imem_ready;
    assign id_en    = (r_state == ST_DECODE);
    assign ex_en    = (r_state == ST_EXEC);
    assign dmem_req = (r_state == ST_MEM);
    assign dmem_we  = (r_state == ST_MEM) && w_is_store;
    assign wb_en    = (r_state == ST_WB);
    assign pc_we    = w_commit;
    assign fault    = (r_state == ST_FAULT);
    assign state    = r_state;
    // A branch commits in the same EXEC cycle that latches the select, so it
    // takes the freshly decoded value rather than the not-yet-updated register.
    assign pc_sel   = !w_commit ? PCSEL_PC4
                    : (r_state == ST_EXEC) ? w_exec_sel : r_pc_sel;

`ifdef CORE_SEQ_INSTRET_EN
    logic [31:0] r_instret;

    // Retired-instruction counter, one increment per PC commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_instret <= '0;
        else if (w_commit)
            r_instret <= r_instret + 32'd1;
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus pushes the expected per-
// instruction record (state trace, pc_sel at commit, wb/dmem_we counts), a
// monitor pops and compares it at every commit or fault entry.
module tb_core_sequencer;

    logic        clk, rst, run;
    logic        imem_req, imem_ready, if_en;
    logic [6:0]  opcode;
    logic        id_en, ex_en, PC_src, jalr;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        wb_en, pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] instret;

    core_sequencer #(.MEM_TIMEOUT(3)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_ready(imem_ready), .if_en(if_en),
        .opcode(opcode), .id_en(id_en), .ex_en(ex_en),
        .PC_src(PC_src), .jalr(jalr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .wb_en(wb_en), .pc_we(pc_we), .pc_sel(pc_sel),
        .state(state), .fault(fault), .instret(instret)
    );

    typedef struct {
        string      name;
        bit         is_fault;
        string      trace;
        logic [1:0] sel;
        int         wb;
        int         dwe;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit   v_pcsrc = 0, v_jalr = 0;
    int   imem_wait = 0, dmem_wait = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic void chk_s(input string nm, input string act, input string req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%s required=%s", nm, act, req);
        end
    endfunction

    function automatic int exp_ir(input int n);
`ifdef CORE_SEQ_INSTRET_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Memory / EX-flag responder: readies after a programmed wait; PC_src and
    // jalr carry the inverted value outside EXEC to show they are ignored there.
    initial begin
        int icnt, dcnt;
        icnt = 0; dcnt = 0;
        imem_ready = 0; dmem_ready = 0; PC_src = 0; jalr = 0;
        forever begin
            @(posedge clk); #2;
            if (state == 3'd1) begin imem_ready = (icnt >= imem_wait); icnt++; end
            else begin imem_ready = 0; icnt = 0; end
            if (state == 3'd4) begin dmem_ready = (dcnt >= dmem_wait); dcnt++; end
            else begin dmem_ready = 0; dcnt = 0; end
            PC_src = (state == 3'd3) ? v_pcsrc : !v_pcsrc;
            jalr   = (state == 3'd3) ? v_jalr  : !v_jalr;
        end
    end

    // Monitor: build the state trace of the instruction in flight and check it
    // against the scoreboard when it commits or faults.
    string tr = "";
    int    wbc = 0, dwc = 0, badsel = 0;
    bit    fault_seen = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            tr = ""; wbc = 0; dwc = 0; badsel = 0; fault_seen = 0;
        end else begin
            if (state != 3'd0 && state != 3'd6) begin
                tr = {tr, $sformatf("%0d", state)};
                wbc += int'(wb_en);
                dwc += int'(dmem_we);
                if (!pc_we && pc_sel != 2'b00) badsel++;
            end
            if (pc_we || (fault && !fault_seen)) begin
                if (fault) fault_seen = 1;
                chk("queue_nonempty", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk({e.name, ".kind"}, 64'(fault), 64'(e.is_fault));
                    chk_s({e.name, ".trace"}, tr, e.trace);
                    chk({e.name, ".pc_sel"}, 64'(pc_sel), 64'(e.sel));
                    chk({e.name, ".wb_cycles"}, 64'(wbc), 64'(e.wb));
                    chk({e.name, ".dmem_we_cycles"}, 64'(dwc), 64'(e.dwe));
                    chk({e.name, ".pc_sel_off_commit"}, 64'(badsel), 64'd0);
                end
                tr = ""; wbc = 0; dwc = 0; badsel = 0;
            end
        end
    end

    task automatic run_instr(input string nm, input logic [6:0] opc, input bit psrc, input bit jr,
                             input int iw, input int dw, input bit drop, input bit is_f,
                             input string trace, input logic [1:0] sel, input int wb, input int dwe);
        exp_t e;
        bit done;
        e.name = nm; e.is_fault = is_f; e.trace = trace; e.sel = sel; e.wb = wb; e.dwe = dwe;
        q.push_back(e);
        opcode = opc; v_pcsrc = psrc; v_jalr = jr; imem_wait = iw; dmem_wait = dw; run = 1;
        done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (drop && state == 3'd2) run = 0;
            if (pc_we || fault) begin done = 1; break; end
        end
        if (!done) chk({nm, ".completion_timeout"}, 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 rst = 1;
        #1;
        chk("reset.state", 64'(state), 64'd0);
        chk("reset.fault", 64'(fault), 64'd0);
        @(negedge clk); #2 rst = 0;
    endtask

    initial begin
        bit hit;
        rst = 1; run = 0; opcode = 7'b0;
        #3;
        chk("reset.outputs",
            {18'd0, instret, imem_req, if_en, id_en, ex_en, dmem_req, dmem_we, wb_en, pc_we, pc_sel, state, fault},
            64'd0);
        @(negedge clk); rst = 0;

        run_instr("alu",    7'b0110011, 0, 0, 0, 0, 0, 0, "1235",    2'b00, 1, 0);
        run_instr("load",   7'b0000011, 0, 0, 0, 2, 0, 0, "1234445", 2'b00, 1, 0);
        run_instr("store",  7'b0100011, 0, 0, 0, 1, 0, 0, "12344",   2'b00, 0, 2);
        chk("instret.after3", 64'(instret), 64'(exp_ir(3)));
        run_instr("br_tk",  7'b1100011, 1, 0, 0, 0, 0, 0, "123",     2'b01, 0, 0);
        run_instr("br_nt",  7'b1100011, 0, 0, 0, 0, 0, 0, "123",     2'b00, 0, 0);
        run_instr("jal",    7'b1101111, 1, 0, 0, 0, 0, 0, "1235",    2'b01, 1, 0);
        run_instr("jalr",   7'b1100111, 1, 1, 0, 0, 0, 0, "1235",    2'b10, 1, 0);
        run_instr("lui_iw3",7'b0110111, 0, 0, 3, 0, 0, 0, "1111235", 2'b00, 1, 0);
        run_instr("opimm_drop", 7'b0010011, 0, 0, 0, 0, 1, 0, "1235", 2'b00, 1, 0);
        chk("drop.idle_after_commit", 64'(state), 64'd0);
        @(negedge clk); @(negedge clk);
        chk("drop.idle_hold", {62'd0, imem_req, state == 3'd0}, 64'd1);
        chk("instret.after9", 64'(instret), 64'(exp_ir(9)));

        run_instr("illegal", 7'b0000000, 0, 0, 0, 0, 0, 1, "123", 2'b00, 0, 0);
        for (int k = 0; k < 3; k++) @(negedge clk);
        chk("illegal.hold_state", 64'(state), 64'd6);
        chk("illegal.hold_fault", 64'(fault), 64'd1);
        chk("illegal.quiet", {56'd0, imem_req, id_en, ex_en, dmem_req, wb_en, pc_we, pc_sel}, 64'd0);
        pulse_reset();

        run_instr("imem_tmo", 7'b0110011, 0, 0, 100, 0, 0, 1, "1111", 2'b00, 0, 0);
        for (int k = 0; k < 3; k++) @(negedge clk);
        chk("imem_tmo.hold_state", 64'(state), 64'd6);
        chk("imem_tmo.hold_fault", 64'(fault), 64'd1);
        imem_wait = 0;
        pulse_reset();

        opcode = 7'b0000011; dmem_wait = 3; v_pcsrc = 0; v_jalr = 0; run = 1;
        hit = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (state == 3'd4) begin hit = 1; break; end
        end
        chk("midmem.reached", 64'(hit), 64'd1);
        #2 rst = 1; run = 0;
        #1;
        chk("midmem.outputs",
            {18'd0, instret, imem_req, if_en, id_en, ex_en, dmem_req, dmem_we, wb_en, pc_we, pc_sel, state, fault},
            64'd0);
        @(negedge clk); #2 rst = 0;

        run_instr("auipc_after_rst", 7'b0010111, 0, 0, 0, 0, 0, 0, "1235", 2'b00, 1, 0);
        chk("instret.after_rst", 64'(instret), 64'(exp_ir(1)));
        run = 0;
        @(negedge clk); @(negedge clk);
        chk("scoreboard.drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the unpipelined RISC-V core. It steps one instruction at a time through the IF, ID, EX, MEM and WB stages, and handshakes with instruction and data memory. It also decides the next-PC source from the EX-stage `PC_src`/`jalr` flags and drives the enables that the datapath stages already expose.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: extra wait cycles allowed for `imem_ready`/`dmem_ready` before a fault.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `run`  in  1  level; permits fetching of new instructions
- `imem_req`  out  1  instruction fetch request
- `imem_ready`  in  1  instruction word valid this cycle
- `if_en`  out  1  latch fetched instruction / PC_4
- `opcode`  in  7  opcode of the latched instruction
- `id_en`  out  1  decode/register-read enable
- `ex_en`  out  1  EX stage enable
- `PC_src`  in  1  EX: branch/jal taken
- `jalr`  in  1  EX: jalr target selected
- `dmem_req`  out  1  data memory request
- `dmem_we`  out  1  data memory write (store)
- `dmem_ready`  in  1  data access complete
- `wb_en`  out  1  register file write enable
- `pc_we`  out  1  PC update strobe (commit)
- `pc_sel`  out  2  00 PC_4, 01 PC+imm, 10 jalr result
- `state`  out  3  current state encoding
- `fault`  out  1  sticky fault flag
- `instret`  out  32  retired count (only with macro)

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6.
- IDLE: moves to FETCH when `run`=1.
- FETCH: `imem_req`=1. When `imem_ready`=1, pulse `if_en` and go to DECODE.
- DECODE: `id_en`=1 for one cycle, then go to EXEC.
- EXEC: `ex_en`=1 for one cycle. In this cycle, register `pc_sel_q`:
  - `jalr`=1 → 10
  - else `PC_src`=1 → 01
  - else → 00
- Next state from EXEC, by opcode:
  - load 0000011 / store 0100011 → MEM
  - branch 1100011 → commit
  - 0110011, 0010011, 0110111, 0010111, 1101111, 1100111 → WB
  - anything else → FAULT
- MEM: `dmem_req`=1, with `dmem_we`=1 only for stores. On `dmem_ready`, a load goes to WB and a store commits.
- WB: `wb_en`=1 for one cycle, then commit.
- Commit is not a separate state. It is the last cycle of EXEC (branch), MEM (store) or WB:
  - `pc_we`=1 and `pc_sel`=`pc_sel_q`.
  - Next state is FETCH if `run`=1, else IDLE.
- `run` dropping mid-instruction does not abort; the current instruction completes and commits.
- Wait timeout:
  - A counter of width clog2(MEM_TIMEOUT+1) clears on entry to FETCH or MEM.
  - It increments on each cycle where ready=0.
  - If ready=0 while the counter equals MEM_TIMEOUT, the next state is FAULT.
  - Ready is therefore accepted in any of the first MEM_TIMEOUT+1 request cycles.
- FAULT:
  - All enables and requests are 0; `fault`=1.
  - Exit only via `rst`.
- All enables and requests are decoded from the registered state (Moore), except `if_en` and the MEM→commit/WB transition, which qualify on the ready inputs.

## Timing
- Reset (async) drives every output to 0: state=IDLE, `pc_sel_q`=00, counter=0, `fault`=0, `instret`=0. This holds even mid-transaction; the outstanding request drops immediately.
- Cycle counts with zero-wait memory, counting the FETCH cycle:
  - ALU / jump: 4 cycles (F, D, E, W)
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
- Each memory wait cycle adds 1.
- `pc_we` is high for exactly one cycle per instruction.
- `pc_sel` is 00 in every cycle except commit.
- The cycle after a commit with `run`=1 is FETCH, so there is no bubble.
- `PC_src`/`jalr` are sampled only in EXEC and ignored elsewhere.

## Configuration
- `CORE_SEQ_INSTRET_EN` defined:
  - 32-bit `instret` register increments on every `pc_we` cycle.
  - Wraps 0xFFFFFFFF → 0.
  - Reset value 0.
- Not defined:
  - `instret` is tied to 0.
  - No counter register is synthesized.

## Structure
- Package `core_seq_pkg` holds:
  - state encoding constants
  - RV32I opcode constants (LOAD, STORE, BRANCH, OP, OP_IMM, LUI, AUIPC, JAL, JALR)
  - `pc_sel` encodings
- Sub-module `seq_opclass` is a combinational opcode classifier. It maps `opcode` → is_load, is_store, is_branch, needs_wb, illegal.

## Test plan
- Reset, `run`=1, opcode 0110011, memory readies tied to 1:
  - states 1,2,3,5 in sequence
  - `wb_en` and `pc_we` high in cycle 4
  - `pc_sel`=00
- Load 0000011, `dmem_ready` low for 2 cycles:
  - MEM lasts 3 cycles with `dmem_we`=0
  - then WB
  - commit in cycle 7
- Branch 1100011 with `PC_src`=1 in EXEC:
  - commit in EXEC with `pc_sel`=01
  - `wb_en` never asserted
- Jalr 1100111 with `jalr`=1 and `PC_src`=1: `pc_sel`=10 at the WB commit.
- Timeout:
  - MEM_TIMEOUT=3, `imem_ready` held 0 → FAULT after 4 FETCH cycles, `fault`=1.
  - Opcode 0000000 → FAULT out of EXEC.
  - Both hold until `rst`.
- Other checks:
  - `rst` asserted mid-MEM: outputs 0 asynchronously.
  - `run` dropped during DECODE: instruction commits, then IDLE.
  - With `CORE_SEQ_INSTRET_EN`, `instret`=3 after three instructions.
